i2d_imem: RTL and testbench
===========================

# i2d_imem

Instruction-memory Wishbone-style responder for the i2d core: the slave end of the fetch bus driven by the instruction fetch stage. It decodes the fetch address, inserts a programmable number of retry (wait) cycles, then acknowledges with the addressed instruction word. Misaligned or out-of-range fetches are answered with an error. A side load port fills the memory before and during execution.

## Interface

- `AW`, 8: word-address width; memory depth is 2^AW 32-bit words.
- `BASE`, 32'h0000_0000: byte address of word 0; must be aligned to 4·2^AW.
- `WAIT_CYC`, 1: retry cycles inserted before each ack; range 0..15.

- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-low reset.
- `adr_i` in 32: fetch byte address.
- `dat_o` out 32: instruction word; valid only while `ack_o`=1, otherwise 0.
- `ack_o` out 1: fetch complete, `dat_o` valid this cycle.
- `rty_o` out 1: not ready; fetcher must hold `adr_i`.
- `err_o` out 1: fetch fault (misaligned or out of range).
- `ld_we` in 1: load-port write strobe.
- `ld_adr` in AW: load-port word address.
- `ld_dat` in 32: load-port write data.

## Operation

- Response rule: every cycle exactly one of `ack_o`, `rty_o`, `err_o` is 1. The fetcher treats "none" as an error, so this is mandatory, including in reset.
- Decode: `off = adr_i - BASE` (32-bit wrap). Error when `adr_i[1:0] != 0` or `off >= 4·2^AW`. Word index is `off[AW+1:2]`.
- State: `cnt` (4 bits) and `adr_q` (32 bits, the last presented address).
- Priority per cycle, highest first:
  1. `rst`=0: `rty_o`=1. `cnt`←0, `adr_q`←0.
  2. Error decode: `err_o`=1. `cnt`←0, `adr_q`←`adr_i`.
  3. `ld_we`=1 (port conflict): `rty_o`=1. The write is performed. `cnt` holds, `adr_q`←`adr_i`.
  4. `adr_i != adr_q` (new or changed address): `cnt` is treated as 0 for this cycle.
     - If `WAIT_CYC`=0: `ack_o`=1, `cnt`←0.
     - Otherwise: `rty_o`=1, `cnt`←1.
     - `adr_q`←`adr_i`.
  5. Effective `cnt < WAIT_CYC`: `rty_o`=1, `cnt`←`cnt`+1.
  6. Effective `cnt == WAIT_CYC`: `ack_o`=1, `dat_o`=mem[index], `cnt`←0.
- After an ack, `cnt`=0. A following fetch at the same address (fetcher stalled by `set_pc` to the same PC) again waits `WAIT_CYC` cycles.
- An address change during a wait sequence restarts the count. No partial credit is carried over.
- Load port:
  - Writes happen at posedge when `ld_we`=1; `ld_adr` is always in range.
  - Reads are combinational from the array. A same-cycle read of the word being written returns the old value; the new value is visible the next cycle.
- Memory contents are not affected by reset and are undefined until loaded.

## Timing

- Fetch latency is `WAIT_CYC`+1 cycles from first presentation of an address to ack, with no `ld_we` in between.
- Throughput is one word per `WAIT_CYC`+1 cycles when the fetcher advances PC by 4 after each ack.
- Each `ld_we` cycle during a fetch adds exactly one cycle of latency.
- `ack_o`, `rty_o`, `err_o` and `dat_o` are combinational from `adr_i`, `ld_we`, `cnt` and `adr_q`.
- Outputs while in reset: `rty_o`=1, `ack_o`=0, `err_o`=0, `dat_o`=0.
- Reset asserted mid-wait: next cycle after release starts a fresh count, since `adr_q`=0 and `cnt`=0.

## Test plan

- Reset then fetch: `WAIT_CYC`=1, `BASE`=0, mem[0]=32'h1234_5678, `adr_i`=0 held.
  - In reset: `rty_o`=1.
  - After reset release: cycle 1 gives `rty_o`=1; cycle 2 gives `ack_o`=1 with `dat_o`=32'h1234_5678.
- Sequential stream: mem[1..3] loaded, fetcher steps 4, 8, 12 after each ack.
  - Ack every 2nd cycle with the correct words.
  - Never a cycle with zero or multiple responses.
- Zero wait (`WAIT_CYC`=0) and `WAIT_CYC`=3:
  - Ack on the first cycle of each address for 0.
  - Three `rty_o` cycles before each ack for 3.
- Errors with `AW`=8:
  - `adr_i`=32'h0000_0002 gives `err_o`=1 immediately.
  - `adr_i`=32'h0000_0400 gives `err_o`=1.
  - `BASE`=32'h1000_0000 with `adr_i`=32'h0FFF_FFFC gives `err_o`=1 (wrap-around).
  - Following aligned fetch gets the full `WAIT_CYC`+1 latency.
- Load conflict: `WAIT_CYC`=1, `ld_we` pulsed on the ack cycle of word 5 with `ld_adr`=5, `ld_dat`=32'hDEAD_BEEF.
  - That cycle gives `rty_o`=1.
  - The next cycle gives `ack_o`=1 with `dat_o`=32'hDEAD_BEEF.
- Address change mid-wait: `WAIT_CYC`=3, `adr_i` switched 0→16 after 2 `rty_o` cycles.
  - Three further `rty_o` cycles, then ack with mem[4].

Source files
------------

// File: rtl/i2d_imem.sv
// i2d_imem: instruction-memory responder on the i2d fetch bus.
//
// Decodes the fetch byte address against BASE, stalls the fetcher with
// WAIT_CYC retry cycles per fetch, then acknowledges with the addressed
// word. Misaligned or out-of-range addresses get an immediate error.
// A side load port writes the array at any time (including during reset).
//
// Ports:
//   clk     clock, all state on posedge
//   rst     synchronous reset, active low
//   adr_i   fetch byte address (held by the fetcher while rty_o=1)
//   dat_o   instruction word, valid only with ack_o, otherwise 0
//   ack_o   fetch complete this cycle
//   rty_o   not ready, hold adr_i
//   err_o   fetch fault (misaligned or out of range)
//   ld_we   load-port write strobe
//   ld_adr  load-port word address
//   ld_dat  load-port write data
//
// Exactly one of ack_o / rty_o / err_o is high in every cycle.
module i2d_imem #(
  parameter int          AW       = 8,
  parameter logic [31:0] BASE     = 32'h0000_0000,
  parameter int          WAIT_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   adr_i,
  output logic [31:0]   dat_o,
  output logic          ack_o,
  output logic          rty_o,
  output logic          err_o,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_adr,
  input  logic [31:0]   ld_dat
);

  // Byte span of the array; one extra bit so AW up to 30 still compares.
  localparam logic [32:0] SPAN   = 33'd4 << AW;
  localparam logic [3:0]  WAIT_Q = 4'(WAIT_CYC);

  logic [31:0]   mem [2**AW];
  logic [3:0]    cnt;
  logic [3:0]    cnt_d;
  logic [3:0]    cnt_eff;
  logic [31:0]   adr_q;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          fault;

  // Offset wraps modulo 2^32, so addresses below BASE land far out of range.
  function automatic logic decode_fault(input logic [31:0] a, input logic [31:0] o);
    return (a[1:0] != 2'b00) || ({1'b0, o} >= SPAN);
  endfunction

  assign off     = adr_i - BASE;
  assign idx     = off[AW+1:2];
  assign fault   = decode_fault(adr_i, off);
  // A new or changed address forfeits any wait already counted.
  assign cnt_eff = (adr_i != adr_q) ? 4'd0 : cnt;

  always_comb begin
    ack_o = 1'b0;
    rty_o = 1'b0;
    err_o = 1'b0;
    dat_o = 32'd0;
    cnt_d = cnt;
    if (!rst) begin
      rty_o = 1'b1;
      cnt_d = 4'd0;
    end else if (fault) begin
      err_o = 1'b1;
      cnt_d = 4'd0;
    end else if (ld_we) begin
      // Load port owns the array this cycle: stall, keep the count.
      rty_o = 1'b1;
    end else if (cnt_eff < WAIT_Q) begin
      rty_o = 1'b1;
      cnt_d = cnt_eff + 4'd1;
    end else begin
      ack_o = 1'b1;
      dat_o = mem[idx];
      cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= 4'd0;
      adr_q <= 32'd0;
    end else begin
      cnt   <= cnt_d;
      adr_q <= adr_i;
    end
  end

  // Array is not reset; loads are accepted in any cycle.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_adr] <= ld_dat;
    end
  end

endmodule

// File: tb/tb_i2d_imem.sv
// Testbench for i2d_imem: four instances with different BASE/WAIT_CYC share
// the load port; each gets its own fetch address. A fetch-level reference
// model predicts the response per cycle into a queue; a monitor on the
// falling edge pops and compares against the DUT outputs.
module tb_i2d_imem;

  localparam int N = 4;

  typedef struct packed {
    logic        ack;
    logic        rty;
    logic        err;
    logic [31:0] dat;
  } resp_t;

  logic        clk;
  logic        rst;
  logic [31:0] adr [N];
  logic [31:0] dat [N];
  logic        ack [N];
  logic        rty [N];
  logic        err [N];
  logic        ld_we;
  logic [7:0]  ld_adr;
  logic [31:0] ld_dat;

  int checks   = 0;
  int failures = 0;

  // Reference model state: fetch offset per instance, the address being
  // waited on, cycles still to wait before ack, and the memory image.
  logic [31:0] o   [N];
  logic [31:0] trk [N];
  int          rem [N];
  logic [31:0] mem_m [256];
  resp_t       last_exp [N];
  resp_t       sb_q [$];

  function automatic int wait_of(input int k);
    case (k)
      0:       return 0;
      1:       return 1;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [31:0] base_of(input int k);
    return (k == 3) ? 32'h1000_0000 : 32'h0000_0000;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    i2d_imem #(
      .AW      (8),
      .BASE    ((g == 3) ? 32'h1000_0000 : 32'h0000_0000),
      .WAIT_CYC((g == 0) ? 0 : ((g == 1) ? 1 : ((g == 2) ? 3 : 2)))
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .adr_i (adr[g]),
      .dat_o (dat[g]),
      .ack_o (ack[g]),
      .rty_o (rty[g]),
      .err_o (err[g]),
      .ld_we (ld_we),
      .ld_adr(ld_adr),
      .ld_dat(ld_dat)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply this cycle's stimulus, predict every instance's response, then
  // advance to just after the next rising edge.
  task automatic step();
    resp_t       e;
    logic [31:0] a;
    logic [31:0] off;
    for (int k = 0; k < N; k++) begin
      a      = base_of(k) + o[k];
      adr[k] = a;
      off    = a - base_of(k);
      e      = '0;
      if (!rst) begin
        e.rty  = 1'b1;
        trk[k] = 32'd0;
        rem[k] = wait_of(k);
      end else if (a[1:0] != 2'b00 || off >= 32'd1024) begin
        e.err  = 1'b1;
        trk[k] = a;
        rem[k] = wait_of(k);
      end else if (ld_we) begin
        e.rty  = 1'b1;
        trk[k] = a;
      end else begin
        if (a != trk[k]) begin
          trk[k] = a;
          rem[k] = wait_of(k);
        end
        if (rem[k] == 0) begin
          e.ack  = 1'b1;
          e.dat  = mem_m[off[9:2]];
          rem[k] = wait_of(k);
        end else begin
          e.rty  = 1'b1;
          rem[k] = rem[k] - 1;
        end
      end
      last_exp[k] = e;
      sb_q.push_back(e);
    end
    if (ld_we) mem_m[ld_adr] = ld_dat;
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [31:0] v);
    for (int k = 0; k < N; k++) o[k] = v;
  endtask

  // Monitor: one expected response per instance per cycle.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() >= N) begin
        for (int k = 0; k < N; k++) begin
          e = sb_q.pop_front();
          checks++;
          if ({ack[k], rty[k], err[k], dat[k]} !== e) begin
            failures++;
            $display("FAIL resp[%0d] t=%0t adr=%h got ack=%b rty=%b err=%b dat=%h want ack=%b rty=%b err=%b dat=%h",
                     k, $time, adr[k], ack[k], rty[k], err[k], dat[k], e.ack, e.rty, e.err, e.dat);
          end
          checks++;
          if ((32'(ack[k]) + 32'(rty[k]) + 32'(err[k])) != 32'd1) begin
            failures++;
            $display("FAIL onehot[%0d] t=%0t got ack=%b rty=%b err=%b want exactly one",
                     k, $time, ack[k], rty[k], err[k]);
          end
        end
      end
    end
  end

  initial begin
    int r;
    rst    = 1'b0;
    ld_we  = 1'b0;
    ld_adr = 8'd0;
    ld_dat = 32'd0;
    for (int k = 0; k < N; k++) begin
      o[k]   = 32'd0;
      adr[k] = base_of(k);
      trk[k] = 32'd0;
      rem[k] = wait_of(k);
    end
    @(posedge clk);
    #1;

    // Reset with preload of words 0..15 (word 0 fixed).
    for (int i = 0; i < 16; i++) begin
      ld_we  = 1'b1;
      ld_adr = 8'(i);
      ld_dat = (i == 0) ? 32'h1234_5678 : $urandom();
      step();
    end
    ld_we = 1'b0;
    step();

    // Release reset with address 0 held.
    rst = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // Sequential stream: each fetcher advances by 4 after its own ack.
    set_all(32'd4);
    for (int i = 0; i < 24; i++) begin
      step();
      for (int k = 0; k < N; k++)
        if (last_exp[k].ack) o[k] = (o[k] + 32'd4) & 32'h3C;
    end

    // Errors: misaligned, past the end, below BASE (wrap), then a good fetch.
    set_all(32'd2);           step();
    set_all(32'h0000_0400);   step();
    set_all(32'hFFFF_FFFC);   step();
    set_all(32'd8);
    for (int i = 0; i < 5; i++) step();

    // Load conflict on the ack cycle of word 5 for the WAIT_CYC=1 instance.
    set_all(32'd20);
    step();
    ld_we  = 1'b1;
    ld_adr = 8'd5;
    ld_dat = 32'hDEAD_BEEF;
    step();
    ld_we = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Address change mid-wait: 0 for two cycles, then 16.
    set_all(32'd0);
    step();
    step();
    set_all(32'd16);
    for (int i = 0; i < 6; i++) step();

    // Reset mid-wait, then a fresh count.
    set_all(32'd4);
    step();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < N; k++) begin
        r = $urandom_range(0, 99);
        if (r < 60)      o[k] = o[k];
        else if (r < 85) o[k] = 32'(4 * $urandom_range(0, 15));
        else if (r < 92) o[k] = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
        else if (r < 97) o[k] = 32'(1024 + 4 * $urandom_range(0, 63));
        else             o[k] = 32'hFFFF_FFFC;
      end
      ld_we  = ($urandom_range(0, 99) < 15);
      ld_adr = 8'($urandom_range(0, 15));
      ld_dat = $urandom();
      rst    = ($urandom_range(0, 99) >= 2);
      step();
    end
    ld_we = 1'b0;
    rst   = 1'b1;
    step();

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending want 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
